// File: rtl/output_iface.sv
// rtl/output_iface.sv - result capture history with per-nibble change blink for sseg display
module output_iface #(
    parameter int W            = 16,
    parameter int DEPTH        = 4,
    parameter int BLINK_CYCLES = 25000000
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [W-1:0]               data_in,
    input  logic [2:0]                 flags_in,
    input  logic                       cap,
    input  logic                       freeze,
    input  logic [$clog2(DEPTH)-1:0]   sel,
    output logic [W-1:0]               hex_word,
    output logic [2:0]                 flags_out,
    output logic [W/4-1:0]             blank,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       busy
);
    localparam int ND = W / 4;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = W + 3;
    localparam int TW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [CW-1:0] FULL  = CW'(DEPTH);
    localparam logic [TW-1:0] TLAST = TW'(BLINK_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, OFF, ON} state_t;

    logic [EW-1:0] hist [DEPTH];
    logic          cap_q;
    logic          push;
    state_t        state_q, state_d;
    logic [1:0]    ph_q, ph_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [ND-1:0] chg;
    logic          sel_valid;
    logic [EW-1:0] entry;

    assign push = cap & ~cap_q & ~freeze;

    // Entry layout is {data, flags}; hist[0] is always the newest capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
            count <= '0;
            cap_q <= 1'b0;
        end else begin
            cap_q <= cap;
            if (push) begin
                hist[0] <= {data_in, flags_in};
                for (int i = 1; i < DEPTH; i++) hist[i] <= hist[i-1];
                if (count != FULL) count <= count + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ph_q    <= 2'd0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            timer_q <= timer_d;
        end
    end

    // A push always restarts the OFF/ON/OFF/ON sequence, even mid-blink.
    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        timer_d = timer_q;
        if (push) begin
            state_d = OFF;
            ph_d    = 2'd0;
            timer_d = '0;
        end else if (state_q != IDLE) begin
            if (timer_q == TLAST) begin
                timer_d = '0;
                ph_d    = ph_q + 2'd1;
                if (state_q == ON && ph_q == 2'd3) state_d = IDLE;
                else if (state_q == OFF)           state_d = ON;
                else                               state_d = OFF;
            end else begin
                timer_d = timer_q + 1'b1;
            end
        end
    end

    always_comb begin
        chg = '0;
        for (int d = 0; d < ND; d++)
            chg[d] = (hist[0][3+4*d +: 4] != hist[1][3+4*d +: 4]);
        if (count <= CW'(1)) chg = '1;
    end

    assign sel_valid = ({1'b0, sel} < count);
    assign entry     = hist[sel];
    assign busy      = (state_q != IDLE);

    always_comb begin
        hex_word  = '0;
        flags_out = '0;
        blank     = '1;
        if (sel_valid) begin
            hex_word  = entry[EW-1:3];
            flags_out = entry[2:0];
            blank     = (state_q == OFF && sel == '0) ? chg : '0;
        end
    end
endmodule

// File: tb/tb_output_iface.sv
// tb/tb_output_iface.sv - randomized scoreboard bench for output_iface against a queue-based model
module tb_output_iface;
    localparam int W = 16;
    localparam int DEPTH = 4;
    localparam int B = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] data_in = '0;
    logic [2:0]  flags_in = '0;
    logic        cap = 1'b0;
    logic        freeze = 1'b0;
    logic [1:0]  sel = '0;
    logic [15:0] hex_word;
    logic [2:0]  flags_out;
    logic [3:0]  blank;
    logic [2:0]  count;
    logic        busy;

    output_iface #(.W(W), .DEPTH(DEPTH), .BLINK_CYCLES(B)) dut (
        .clk(clk), .reset_n(reset_n), .data_in(data_in), .flags_in(flags_in),
        .cap(cap), .freeze(freeze), .sel(sel), .hex_word(hex_word),
        .flags_out(flags_out), .blank(blank), .count(count), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] hex;
        logic [2:0]  fl;
        logic [3:0]  blank;
        logic [2:0]  cnt;
        logic        busy;
    } exp_t;

    exp_t        sb[$];
    logic [18:0] mh[$];
    int          since;
    bit          active;
    bit          capq;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, got, want);
        end
    endtask

    task automatic model_clear();
        mh.delete();
        active = 0;
        since  = 0;
        capq   = 0;
    endtask

    // Models what the edge just sampled: inputs still hold their pre-edge values.
    task automatic model_edge();
        if (!reset_n) begin
            model_clear();
        end else begin
            if (cap && !capq && !freeze) begin
                mh.push_front({data_in, flags_in});
                if (mh.size() > DEPTH) void'(mh.pop_back());
                active = 1;
                since  = 0;
            end else if (active) begin
                since++;
                if (since >= 4 * B) active = 0;
            end
            capq = cap;
        end
    endtask

    function automatic exp_t expect_now();
        exp_t e;
        logic [18:0] a, b;
        e.cnt   = 3'(mh.size());
        e.busy  = active;
        e.hex   = '0;
        e.fl    = '0;
        e.blank = 4'hF;
        if (int'(sel) < mh.size()) begin
            a = mh[sel];
            e.hex   = a[18:3];
            e.fl    = a[2:0];
            e.blank = 4'h0;
            if (sel == 2'd0 && active && ((since / B) % 2 == 0)) begin
                if (mh.size() == 1) e.blank = 4'hF;
                else begin
                    b = mh[1];
                    for (int d = 0; d < 4; d++) e.blank[d] = (a[3+4*d +: 4] != b[3+4*d +: 4]);
                end
            end
        end
        return e;
    endfunction

    task automatic step(input bit r, input bit c, input bit f, input logic [15:0] d,
                        input logic [2:0] fl, input logic [1:0] s);
        @(posedge clk);
        #1;
        model_edge();
        reset_n  = r;
        cap      = c;
        freeze   = f;
        data_in  = d;
        flags_in = fl;
        sel      = s;
        if (!r) model_clear();
        sb.push_back(expect_now());
    endtask

    task automatic hold(input int k);
        for (int i = 0; i < k; i++) step(reset_n, cap, freeze, data_in, flags_in, sel);
    endtask

    task automatic capture(input logic [15:0] d, input logic [2:0] fl);
        step(1, 1, 0, d, fl, sel);
        step(1, 0, 0, d, fl, sel);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("hex_word",  32'(hex_word),  32'(e.hex));
            check("flags_out", 32'(flags_out), 32'(e.fl));
            check("blank",     32'(blank),     32'(e.blank));
            check("count",     32'(count),     32'(e.cnt));
            check("busy",      32'(busy),      32'(e.busy));
        end
    end

    initial begin
        model_clear();
        step(0, 0, 0, 16'h0, 3'b0, 2'd0);
        hold(2);
        step(1, 0, 0, 16'h0, 3'b0, 2'd0);
        hold(2);

        step(1, 1, 0, 16'h1234, 3'b010, 2'd0);
        hold(2);
        step(1, 0, 0, 16'h1234, 3'b010, 2'd0);
        hold(18);

        capture(16'h1294, 3'b001);
        hold(5);
        step(1, 0, 0, 16'h1294, 3'b001, 2'd1);
        hold(3);
        step(1, 0, 0, 16'h1294, 3'b001, 2'd0);
        hold(14);

        for (int i = 1; i <= 5; i++) capture(16'hA000 + 16'(i), 3'(i));
        for (int s = 0; s < 4; s++) begin
            step(1, 0, 0, 16'h0, 3'b0, 2'(s));
            hold(1);
        end
        step(1, 0, 0, 16'h0, 3'b0, 2'd0);
        hold(16);

        step(1, 1, 1, 16'hBEEF, 3'b111, 2'd0);
        hold(2);
        step(1, 1, 0, 16'hBEEF, 3'b111, 2'd0);
        hold(2);
        step(1, 0, 0, 16'hBEEF, 3'b111, 2'd0);
        hold(2);

        capture(16'hC001, 3'b100);
        hold(9);
        capture(16'hC0F2, 3'b010);
        hold(20);

        capture(16'hD001, 3'b001);
        hold(5);
        step(0, 0, 0, 16'hD001, 3'b001, 2'd0);
        #1;
        check("async_blank", 32'(blank), 32'hF);
        check("async_count", 32'(count), 32'h0);
        check("async_busy",  32'(busy),  32'h0);
        hold(2);
        step(1, 0, 0, 16'h0, 3'b0, 2'd0);
        hold(1);

        for (int i = 0; i < 400; i++) begin
            if (i % 60 == 59) begin
                step(1, 0, 0, data_in, flags_in, 2'd0);
                hold(18);
            end else begin
                step(1, 1'($urandom % 2), ($urandom % 6) == 0,
                     ($urandom % 4 == 0) ? data_in : 16'($urandom),
                     3'($urandom), 2'($urandom % 4));
            end
        end
        hold(2);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/output_iface.md
Name: output_iface

Overview:
- Output-side companion to the switch-driven input interface: captures the CPU's 16-bit result word and Z/N/V flags on a capture strobe.
- Keeps a short history of captured results and presents any selected entry as a 16-bit nibble word for the four sseg digit decoders, plus flags for HEX5.
- After each capture, the nibbles that changed blink briefly, so the operator can see what a KEY0 step modified.

Parameters:
- W, 16, data word width; must be a multiple of 4, giving W/4 displayed digits.
- DEPTH, 4, number of history entries; must be at least 2.
- BLINK_CYCLES, 25000000, clk cycles per blink half-period (0.5 s at 50 MHz).

Ports:
- clk  input  1  system clock (CLOCK_50 domain)
- reset_n  input  1  asynchronous reset, active-low
- data_in  input  W  CPU result word (register C output)
- flags_in  input  3  {Z,N,V} from the CPU status register
- cap  input  1  capture request, level, synchronous to clk; a rising edge triggers one capture
- freeze  input  1  when 1, capture requests are ignored
- sel  input  $clog2(DEPTH)  history index; 0 = newest
- hex_word  output  W  selected entry, feeds sseg instances nibble-wise
- flags_out  output  3  {Z,N,V} of selected entry
- blank  output  W/4  per-digit blank mask; 1 = digit must be driven off (7'b1111111)
- count  output  $clog2(DEPTH)+1  number of valid entries, saturates at DEPTH
- busy  output  1  1 while the blink sequence is running

Behaviour:
- Reset (async, reset_n=0): all history words and flags cleared to 0, count=0, cap_q=0, blink FSM=IDLE, blink timer=0. Outputs while in reset: hex_word=0, flags_out=0, blank=all 1s, busy=0.
- Edge detect: cap_q is a registered copy of cap. push = cap & ~cap_q & ~freeze, evaluated at each posedge clk.
- Push, on the same edge:
  - hist[i] <= hist[i-1] for i=1..DEPTH-1; hist[0] <= {data_in, flags_in}; the oldest entry is dropped.
  - count <= min(count+1, DEPTH).
- freeze=1 during a cap rising edge: that edge is lost. Releasing freeze while cap is still high does not capture. A new rising edge is required.
- Reads are combinational from registers. The entry captured at edge k is visible on hex_word from edge k onward, so latency is 1 cycle from cap sampled high.
- Invalid selection (sel >= count): hex_word=0, flags_out=0, blank=all 1s.
- Blink FSM states: IDLE, OFF, ON. A 2-bit phase counter ph counts half-periods.
  - Any push, from any state: go to OFF, ph=0, timer=0. A push mid-blink restarts the sequence.
  - In OFF/ON: timer increments each cycle. When timer == BLINK_CYCLES-1: timer=0, ph++, state toggles OFF<->ON.
  - When ph==3 and the ON half-period expires: go to IDLE.
  - Sequence: OFF, ON, OFF, ON = 4*BLINK_CYCLES cycles.
  - busy = (state != IDLE).
- Changed-nibble mask chg[d]:
  - chg[d] = 1 if nibble d of hist[0] differs from nibble d of hist[1].
  - If count==1, chg = all 1s.
  - Recomputed combinationally from the current history.
- Blank output:
  - Valid sel: blank = (state==OFF && sel==0) ? chg : 0.
  - Non-zero sel never blinks.
  - A capture identical to the previous entry gives chg=0, so there is no visible blink, but busy still runs the full sequence.
- Timer width is $clog2(BLINK_CYCLES); no wrap past BLINK_CYCLES-1.
- Reset asserted mid-blink: immediate return to the reset state; history is lost.

Test Plan:
- Bench sets BLINK_CYCLES=4.
- Reset/empty: hold reset_n=0, then release with sel=0 -> hex_word=0, flags_out=0, blank=4'b1111, count=0, busy=0.
- First capture: data_in=16'h1234, flags_in=3'b010, pulse cap high 3 cycles -> exactly one push; hex_word=16'h1234, flags_out=3'b010, count=1, blank=4'b1111 for cycles 1-4, 0 for 5-8, 4'b1111 for 9-12, 0 after; busy falls after 16 cycles.
- Changed nibbles: after 16'h1234, capture 16'h1294 -> during OFF phases blank=4'b0010; sel=1 -> hex_word=16'h1234, blank=0.
- History wrap: capture 16'hA001..16'hA005 (5 pushes) -> count=4; sel=0..3 -> 16'hA005, A004, A003, A002; A001 is gone.
- Freeze and restart:
  - freeze=1 with a cap edge -> no change to count or hex_word.
  - freeze=0 with cap still high -> still no change.
  - Push during the second OFF phase -> the sequence restarts at OFF with ph=0; busy stays 1 for a further 16 cycles.
- Async reset mid-blink: assert reset_n=0 between clock edges -> blank=all 1s, count=0, busy=0 immediately, without waiting for a clk edge.
